// File: rtl/uart_rx_core.sv
// UART receive core: 16x oversampled line, 2-of-3 mid-bit vote, configurable
// frame format, frame/parity/break/overrun detection and a show-ahead FIFO.
module uart_rx_core #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_frame_err,
  output logic                 m_parity_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = DATA_BITS + 2;
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_core: CLK_FREQ/(BAUD_RATE*16) must be at least 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_core: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_core: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_core: FIFO_DEPTH must be a power of two >= 2");
  end

  // Two-flop synchroniser; idle-high reset value avoids a phantom start bit.
  logic rx_meta, rx_s;

  // NOTE: non-blocking assignments make both flops sample together; blocking
  // ones would collapse the synchroniser into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           scnt_q, scnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 frame_done, break_hit;
  logic                 bit_val, exp_par;
  logic [ENT_W-1:0]     push_entry;

  assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign exp_par = (PARITY == 1) ? ~(^shift_q) : ^shift_q;
  assign busy    = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      scnt_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      samp_q    <= 2'b11;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      par_bit_q <= par_bit_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case tree can infer a latch.
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    frame_done = 1'b0;
    break_hit  = 1'b0;
    push_entry = '0;

    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d   = S_START;
            scnt_d    = '0;
            bit_cnt_d = '0;
            par_bit_d = 1'b0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
          end
        end
        S_BREAK_WAIT: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd7) samp_d[0] = rx_s;
          if (scnt_q == 4'd8) samp_d[1] = rx_s;

          // Bit decision point: samples 7 and 8 are registered, 9 is live.
          if (scnt_q == 4'd9) begin
            case (state_q)
              S_START:  if (bit_val) state_d = S_IDLE;
              S_DATA:   shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
              S_PARITY: begin
                par_bit_d = bit_val;
                par_err_d = (bit_val != exp_par);
              end
              S_STOP: begin
                frm_err_d = frm_err_q | ~bit_val;
                if (bit_cnt_q == LAST_STOP) begin
                  if (shift_q == '0 && !par_bit_q && !bit_val) begin
                    break_hit = 1'b1;
                    state_d   = S_BREAK_WAIT;
                  end else begin
                    frame_done = 1'b1;
                    push_entry = {frm_err_q | ~bit_val, par_err_q, shift_q};
                    state_d    = S_IDLE;
                  end
                end
              end
              default: ;
            endcase
          end

          if (scnt_q == 4'd15) begin
            case (state_q)
              S_START: begin
                state_d   = S_DATA;
                bit_cnt_d = '0;
              end
              S_DATA: begin
                if (bit_cnt_q == LAST_DATA) begin
                  state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                  bit_cnt_d = '0;
                end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                end
              end
              S_PARITY: begin
                state_d   = S_STOP;
                bit_cnt_d = '0;
              end
              S_STOP:  bit_cnt_d = bit_cnt_q + 4'd1;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Receive FIFO: show-ahead, head entry gated to zero while empty.
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, pop, do_push;

  assign m_valid = (count != '0);
  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop     = m_valid && m_ready;
  assign do_push = frame_done && (!full || pop);

  assign {m_frame_err, m_parity_err, m_data} = m_valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; occupancy is tracked by count, and the
  // outputs are masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      break_det <= 1'b0;
    end else begin
      overrun   <= frame_done && full && !pop;
      break_det <= break_hit;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: an 8N1 instance and a 7E2 instance, each
// checked against a queue of expected frames built from the bits driven.
module tb_uart_rx_core;

  localparam int CLK_FREQ = 16_000_000;
  localparam int BAUD     = 250_000;
  localparam int BIT_CLKS = 64;
  localparam int DEPTH    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rx_a = 1'b1, ready_a = 1'b1;
  logic [7:0] data_a;
  logic       fe_a, pe_a, valid_a, ovr_a, brk_a, busy_a;

  logic       rx_b = 1'b1, ready_b = 1'b1;
  logic [6:0] data_b;
  logic       fe_b, pe_b, valid_b, ovr_b, brk_b, busy_b;

  uart_rx_core #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_a),
    .m_data(data_a), .m_frame_err(fe_a), .m_parity_err(pe_a),
    .m_valid(valid_a), .m_ready(ready_a),
    .overrun(ovr_a), .break_det(brk_a), .busy(busy_a)
  );

  uart_rx_core #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_b),
    .m_data(data_b), .m_frame_err(fe_b), .m_parity_err(pe_b),
    .m_valid(valid_b), .m_ready(ready_b),
    .overrun(ovr_b), .break_det(brk_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  // Model: expected entries {frame_err, parity_err, data} in arrival order.
  logic [9:0] q_a[$];
  logic [8:0] q_b[$];
  int         exp_ovr_a = 0;
  int         exp_brk_a = 0;

  // Monitor bookkeeping, written only by the compare process.
  int         beats_a = 0, beats_b = 0;
  int         vcyc_a = 0, ovr_cyc_a = 0, brk_cyc_a = 0, busy_cyc_a = 0;
  logic [9:0] last_a = '0, held_a = '0, exp_a;
  logic [8:0] last_b = '0, held_b = '0, exp_b;
  logic       hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0] log_a[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_a = 1'b0;
      hold_b = 1'b0;
    end else begin
      if (valid_a) vcyc_a++;
      if (ovr_a)   ovr_cyc_a++;
      if (brk_a)   brk_cyc_a++;
      if (busy_a)  busy_cyc_a++;

      if (hold_a) check("hold_a", {valid_a, fe_a, pe_a, data_a}, {1'b1, held_a});
      if (valid_a && ready_a) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_beat_a: got 0x%0h with no frame expected", {fe_a, pe_a, data_a});
        end else begin
          exp_a = q_a.pop_front();
          check("beat_a", {fe_a, pe_a, data_a}, exp_a);
        end
        beats_a++;
        last_a = {fe_a, pe_a, data_a};
        log_a.push_back(data_a);
      end
      hold_a = valid_a && !ready_a;
      held_a = {fe_a, pe_a, data_a};

      if (hold_b) check("hold_b", {valid_b, fe_b, pe_b, data_b}, {1'b1, held_b});
      if (valid_b && ready_b) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_beat_b: got 0x%0h with no frame expected", {fe_b, pe_b, data_b});
        end else begin
          exp_b = q_b.pop_front();
          check("beat_b", {fe_b, pe_b, data_b}, exp_b);
        end
        beats_b++;
        last_b = {fe_b, pe_b, data_b};
      end
      hold_b = valid_b && !ready_b;
      held_b = {fe_b, pe_b, data_b};
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input bit sel, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (sel) rx_b = bits[i];
      else     rx_a = bits[i];
      wait_clk(BIT_CLKS);
    end
    if (sel) rx_b = 1'b1;
    else     rx_a = 1'b1;
  endtask

  // 8N1 frame; a low stop bit marks a framing error, or a break if data is 0.
  task automatic send_a(input logic [7:0] d, input logic stop);
    if (d == 8'h00 && !stop)              exp_brk_a++;
    else if (q_a.size() >= DEPTH && !ready_a) exp_ovr_a++;
    else                                  q_a.push_back({~stop, 1'b0, d});
    drive_line(1'b0, 16'({stop, d, 1'b0}), 10);
    wait_clk(3 * BIT_CLKS);
  endtask

  // 7E2 frame: even parity means data ones plus parity bit must be even.
  task automatic send_b(input logic [6:0] d, input logic par);
    logic pe;
    pe = (($countones(d) + int'(par)) % 2) != 0;
    q_b.push_back({1'b0, pe, d});
    drive_line(1'b1, 16'({2'b11, par, d, 1'b0}), 11);
    wait_clk(3 * BIT_CLKS);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  int snap_beats, snap_vcyc, snap_ovr, snap_brk, snap_busy, snap_log, snap_exp_ovr;

  initial begin
    // Reset state
    wait_clk(3);
    check("reset_a_outputs", {valid_a, data_a, fe_a, pe_a, ovr_a, brk_a, busy_a}, 32'h0);
    check("reset_b_outputs", {valid_b, data_b, fe_b, pe_b, ovr_b, brk_b, busy_b}, 32'h0);
    rst_n = 1'b1;
    wait_clk(4);
    check("post_reset_idle", {valid_a, busy_a, valid_b, busy_b}, 32'h0);

    // 0xA5 on 8N1: one beat, clean flags, valid for exactly one cycle
    snap_beats = beats_a;
    snap_vcyc  = vcyc_a;
    send_a(8'hA5, 1'b1);
    check("a5_beats", beats_a - snap_beats, 1);
    check("a5_entry", last_a, 10'h0A5);
    check("a5_valid_cycles", vcyc_a - snap_vcyc, 1);

    // 7E2: correct parity, then a wrong parity bit
    send_b(7'h55, 1'b0);
    check("b_parity_ok", last_b, 9'h055);
    send_b(7'h55, 1'b1);
    check("b_parity_err", last_b, 9'h0D5);

    // Low stop bit with non-zero data: framing error, not a break
    snap_brk = brk_cyc_a;
    send_a(8'h3C, 1'b0);
    check("frame_err_entry", last_a, 10'h23C);
    check("frame_err_no_break", brk_cyc_a - snap_brk, 0);

    // Line held low for 12 bit times: one break pulse, no push
    snap_beats = beats_a;
    snap_brk   = brk_cyc_a;
    rx_a = 1'b0;
    wait_clk(12 * BIT_CLKS);
    check("break_busy_held", busy_a, 1'b1);
    rx_a = 1'b1;
    wait_clk(20);
    check("break_busy_released", busy_a, 1'b0);
    check("break_pulse_cycles", brk_cyc_a - snap_brk, 1);
    check("break_no_push", beats_a - snap_beats, 0);
    send_a(8'h11, 1'b1);
    check("after_break_entry", last_a, 10'h011);

    // Five frames into a 4-deep FIFO with no consumer
    ready_a      = 1'b0;
    snap_ovr     = ovr_cyc_a;
    snap_exp_ovr = exp_ovr_a;
    for (int i = 1; i <= 5; i++) send_a(8'(i), 1'b1);
    check("overrun_cycles", ovr_cyc_a - snap_ovr, 1);
    check("overrun_model", ovr_cyc_a - snap_ovr, exp_ovr_a - snap_exp_ovr);
    check("overrun_head", {valid_a, data_a}, 9'h101);
    snap_log = log_a.size();
    ready_a  = 1'b1;
    wait_clk(10);
    check("drain_empty", valid_a, 1'b0);
    check("drain_count", log_a.size() - snap_log, 4);
    for (int i = 0; i < 4; i++) begin
      if (snap_log + i < log_a.size())
        check("drain_order", log_a[snap_log + i], 8'(i + 1));
    end

    // One-tick glitch on the idle line: false start, nothing delivered
    snap_beats = beats_a;
    snap_busy  = busy_cyc_a;
    rx_a = 1'b0;
    wait_clk(4);
    rx_a = 1'b1;
    wait_clk(120);
    check("glitch_went_busy", (busy_cyc_a - snap_busy) != 0, 1'b1);
    check("glitch_back_idle", busy_a, 1'b0);
    check("glitch_no_beat", beats_a - snap_beats, 0);

    // Reset mid-frame with two entries queued
    ready_a = 1'b0;
    send_a(8'h21, 1'b1);
    send_a(8'h42, 1'b1);
    check("queued_head", {valid_a, data_a}, 9'h121);
    rx_a = 1'b0;
    wait_clk(2 * BIT_CLKS);
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame_valid", valid_a, 1'b0);
    q_a.delete();
    rx_a = 1'b1;
    wait_clk(3);
    rst_n   = 1'b1;
    ready_a = 1'b1;
    wait_clk(8);
    check("after_reset_empty", {valid_a, busy_a}, 2'b00);
    send_a(8'h99, 1'b1);
    check("after_reset_entry", last_a, 10'h099);

    wait_clk(20);
    check("model_drained_a", q_a.size(), 0);
    check("model_drained_b", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
